// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/transmitter bundle for the shared UART arbiter.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  localparam int GW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_busy;
  logic                 send_en;
  logic [7:0]           send_data;
  logic [GW-1:0]        grant_id;
  logic                 arb_idle;
  logic                 tx_timeout;
  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, send_en, send_data, grant_id, arb_idle, tx_timeout
  );
  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, send_en, send_data, grant_id, arb_idle, tx_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter with busy-rise timeout.
// Define UART_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin group.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic sys_clk,
  input logic sys_rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t        state, state_d;
  logic [GW-1:0] ptr, pick, nxt, grant_id;
  logic [7:0]    cnt, cnt_d, send_data;
  logic          send_en, send_en_d, tx_timeout, tmo_d, found, grant, ptr_upd;
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef UART_ARB_PRIO0_EN
      if (bus.req_valid[(int'(ptr) + k) % NUM_REQ] && ((int'(ptr) + k) % NUM_REQ) != 0) begin
`else
      if (bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
`endif
        pick  = GW'((int'(ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
`ifdef UART_ARB_PRIO0_EN
    if (bus.req_valid[0]) begin
      pick  = '0;
      found = 1'b1;
    end
`endif
  end
  assign grant = (state == IDLE) && !bus.tx_busy && found;
`ifdef UART_ARB_PRIO0_EN
  assign ptr_upd = grant && (pick != '0);
`else
  assign ptr_upd = grant;
`endif
  assign nxt = (pick == GW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    send_en_d = send_en;
    tmo_d     = 1'b0;
    case (state)
      IDLE: state_d = grant ? LAUNCH : IDLE;
      LAUNCH: begin
        send_en_d = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          send_en_d = 1'b0;
          state_d   = WAIT_DONE;
        end else if (cnt == 8'(BUSY_TIMEOUT - 1)) begin
          send_en_d = 1'b0;
          tmo_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
      end
      WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      send_en    <= 1'b0;
      send_data  <= '0;
      grant_id   <= '0;
      tx_timeout <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      send_en    <= send_en_d;
      tx_timeout <= tmo_d;
      if (grant) begin
        send_data <= bus.req_data[8*int'(pick) +: 8];
        grant_id  <= pick;
      end
      if (ptr_upd) ptr <= nxt;
    end
  end
  assign bus.req_ready  = grant ? (NUM_REQ'(1) << pick) : '0;
  assign bus.send_en    = send_en;
  assign bus.send_data  = send_data;
  assign bus.grant_id   = grant_id;
  assign bus.arb_idle   = (state == IDLE);
  assign bus.tx_timeout = tx_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter (4 requesters, timeout 16).
// Includes a UART transmitter model that goes busy 3 cycles after send_en rises, for 10 cycles.
module tb_uart_tx_arbiter;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic model_en = 1'b1;
  logic man_busy = 1'b0;
  logic model_busy = 1'b0;
  logic prev_en = 1'b0;
  logic mon_prev = 1'b0;
  int dly = 0, bsy = 0;
  int n_checks = 0, n_fail = 0;
  int rdy_cnt = 0, rise_cnt = 0, en_cycles = 0, tmo_cnt = 0;
  logic [3:0] last_rdy = '0;
  logic [7:0] sent_q[$];
  logic [7:0] exp6[4];

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus();
  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;
  assign bus.tx_busy = model_en ? model_busy : man_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      dly = 0;
      bsy = 0;
      model_busy = 1'b0;
    end else begin
      if (bsy > 0) begin
        bsy--;
        model_busy = (bsy > 0);
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          bsy = 10;
          model_busy = 1'b1;
        end
      end
      if (bus.send_en && !prev_en) dly = 3;
    end
    prev_en = bus.send_en;
  end

  always @(negedge sys_clk) begin
    if (|bus.req_ready) begin
      rdy_cnt++;
      last_rdy = bus.req_ready;
      check("ready_onehot", 32'($onehot(bus.req_ready)), 1);
    end
    if (bus.send_en && !mon_prev) begin
      rise_cnt++;
      sent_q.push_back(bus.send_data);
    end
    if (bus.send_en) en_cycles++;
    if (bus.tx_timeout) tmo_cnt++;
    mon_prev = bus.send_en;
  end

  task automatic clr_mon();
    rdy_cnt = 0;
    rise_cnt = 0;
    en_cycles = 0;
    tmo_cnt = 0;
    last_rdy = '0;
    sent_q.delete();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    #1;
    while (!(|bus.req_ready) && n < 60) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check({tag, "_ready_seen"}, 32'(|bus.req_ready), 1);
  endtask

  task automatic wait_rises(input string tag, input int target);
    int n = 0;
    while (rise_cnt < target && n < 400) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check({tag, "_rises"}, 32'(rise_cnt >= target), 1);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_send_en", 32'(bus.send_en), 0);
    check("rst_send_data", 32'(bus.send_data), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
    check("rst_tx_timeout", 32'(bus.tx_timeout), 0);
    check("rst_arb_idle", 32'(bus.arb_idle), 1);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // single request from requester 2
    clr_mon();
    bus.req_data = 32'h00A5_0000;
    bus.req_valid = 4'b0100;
    wait_ready("t1");
    check("t1_ready_vec", 32'(bus.req_ready), 32'h4);
    @(posedge sys_clk); #1;
    bus.req_valid = '0;
    check("t1_launch_en", 32'(bus.send_en), 0);
    check("t1_busy_state", 32'(bus.arb_idle), 0);
    @(posedge sys_clk); #1;
    check("t1_send_en_lat", 32'(bus.send_en), 1);
    check("t1_send_data", 32'(bus.send_data), 32'hA5);
    repeat (40) @(posedge sys_clk);
    #1;
    check("t1_rdy_cnt", 32'(rdy_cnt), 1);
    check("t1_last_rdy", 32'(last_rdy), 32'h4);
    check("t1_rise_cnt", 32'(rise_cnt), 1);
    check("t1_grant_id", 32'(bus.grant_id), 2);
    check("t1_idle", 32'(bus.arb_idle), 1);
    check("t1_no_tmo", 32'(tmo_cnt), 0);

    // all four continuously valid, pointer from reset
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    clr_mon();
    bus.req_data = 32'h1312_1110;
    bus.req_valid = 4'hF;
    wait_rises("t2", 5);
    bus.req_valid = '0;
    repeat (40) @(posedge sys_clk);
    #1;
    check("t2_b0", 32'(sent_q[0]), 32'h10);
    check("t2_b1", 32'(sent_q[1]), 32'h11);
    check("t2_b2", 32'(sent_q[2]), 32'h12);
    check("t2_b3", 32'(sent_q[3]), 32'h13);
    check("t2_b4", 32'(sent_q[4]), 32'h10);
    check("t2_no_tmo", 32'(tmo_cnt), 0);

    // timeout with tx_busy tied low, requester 1 held valid
    model_en = 1'b0;
    man_busy = 1'b0;
    clr_mon();
    bus.req_data = 32'h0000_5C00;
    bus.req_valid = 4'b0010;
    wait_ready("t3");
    begin
      int n = 0;
      while (!bus.tx_timeout && n < 40) begin
        @(posedge sys_clk); #1;
        n++;
      end
    end
    check("t3_tmo_seen", 32'(bus.tx_timeout), 1);
    check("t3_en_cycles", 32'(en_cycles), 16);
    check("t3_idle", 32'(bus.arb_idle), 1);
    check("t3_send_en_low", 32'(bus.send_en), 0);
    check("t3_regrant", 32'(bus.req_ready), 32'h2);
    check("t3_send_data", 32'(bus.send_data), 32'h5C);
    @(posedge sys_clk); #1;
    check("t3_tmo_pulse", 32'(bus.tx_timeout), 0);
    check("t3_grant_id", 32'(bus.grant_id), 1);
    bus.req_valid = '0;
    repeat (25) @(posedge sys_clk);
    #1;
    check("t3_tmo_cnt", 32'(tmo_cnt), 2);
    check("t3_en_total", 32'(en_cycles), 32);

    // transmitter already busy
    clr_mon();
    man_busy = 1'b1;
    bus.req_data = 32'h0000_003C;
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #1;
      check("t4_hold_ready", 32'(bus.req_ready), 0);
      check("t4_hold_en", 32'(bus.send_en), 0);
    end
    man_busy = 1'b0;
    #1;
    check("t4_ready", 32'(bus.req_ready), 32'h1);
    @(posedge sys_clk); #1;
    bus.req_valid = '0;
    check("t4_grant_id", 32'(bus.grant_id), 0);
    check("t4_send_data", 32'(bus.send_data), 32'h3C);
    repeat (40) @(posedge sys_clk);
    #1;
    model_en = 1'b1;

    // reset while in WAIT_DONE
    clr_mon();
    bus.req_data = 32'h0077_0000;
    bus.req_valid = 4'b0100;
    wait_ready("t5");
    @(posedge sys_clk); #1;
    bus.req_valid = '0;
    begin
      int n = 0;
      while (!bus.tx_busy && n < 20) begin
        @(posedge sys_clk); #1;
        n++;
      end
    end
    check("t5_busy_seen", 32'(bus.tx_busy), 1);
    @(posedge sys_clk); #1;
    check("t5_pre_idle", 32'(bus.arb_idle), 0);
    check("t5_pre_gid", 32'(bus.grant_id), 2);
    sys_rst_n = 1'b0;
    #1;
    check("t5_rst_en", 32'(bus.send_en), 0);
    check("t5_rst_idle", 32'(bus.arb_idle), 1);
    check("t5_rst_gid", 32'(bus.grant_id), 0);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    bus.req_data = 32'h4400_0041;
    bus.req_valid = 4'b1001;
    wait_ready("t5b");
    check("t5_first_req0", 32'(bus.req_ready), 32'h1);
    @(posedge sys_clk); #1;
    bus.req_valid = '0;
    repeat (40) @(posedge sys_clk);
    #1;

    // requesters 0 and 3 valid together; pointer now 1
    clr_mon();
    bus.req_data = 32'h2300_0020;
    bus.req_valid = 4'b1001;
    wait_rises("t6a", 3);
    bus.req_valid = 4'b1000;
    wait_rises("t6b", 4);
    bus.req_valid = '0;
    repeat (40) @(posedge sys_clk);
    #1;
`ifdef UART_ARB_PRIO0_EN
    exp6 = '{8'h20, 8'h20, 8'h20, 8'h23};
`else
    exp6 = '{8'h23, 8'h20, 8'h23, 8'h23};
`endif
    for (int i = 0; i < 4; i++) check($sformatf("t6_b%0d", i), 32'(sent_q[i]), 32'(exp6[i]));
    check("t6_count", 32'(rise_cnt), 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
